// File: rtl/cr_had_pkg.sv
// Shared HAD definitions: trace-count FSM states and counter defaults.
package cr_had_pkg;

  localparam int CNT_WIDTH_DEF = 8;

  // A programmed count of zero would never expire, so it is stored as this value.
  localparam int ZERO_WR_VALUE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_PEND  = 2'b10,
    ST_DBG   = 2'b11
  } trace_st_e;

endpackage

// File: rtl/cr_had_trace_cnt.sv
// HAD trace counter: counts qualifying retirements and raises a registered
// trace request on expiry, holding it until the IU acknowledges trace entry.
module cr_had_trace_cnt
  import cr_had_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 cpuclk,
  input  logic                 hadrst,
  input  logic                 regs_trace_en,
  input  logic                 regs_trace_chgflw_only,
  input  logic                 regs_trace_cnt_wr,
  input  logic [CNT_WIDTH-1:0] regs_trace_cnt_wdata,
  input  logic                 iu_had_retire_vld,
  input  logic                 iu_had_chgflw_vld,
  input  logic                 iu_yy_xx_dbgon,
  input  logic                 iu_had_dbg_disable_for_tee,
  input  logic                 iu_had_trace_occur_vld,
  input  logic                 had_yy_xx_exit_dbg,
  output logic                 trace_ctrl_req,
  output logic                 trace_ctrl_req_for_dbg_disable,
  output logic [CNT_WIDTH-1:0] trace_regs_cnt,
  output logic                 trace_regs_pend
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] norm_wdata(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(ZERO_WR_VALUE) : v;
  endfunction

  trace_st_e            state_p1;
  trace_st_e            state_nxt;
  logic [CNT_WIDTH-1:0] cnt_p1;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH-1:0] sh_p1;
  logic [CNT_WIDTH-1:0] sh_nxt;
  logic [CNT_WIDTH-1:0] wr_val;
  logic                 ev;
  logic                 pend_nxt;
  logic                 req_p1;
  logic                 req_dis_p1;
  logic                 pend_p1;

  assign ev = iu_had_retire_vld && !iu_yy_xx_dbgon &&
              (!regs_trace_chgflw_only || iu_had_chgflw_vld);

  assign wr_val = norm_wdata(regs_trace_cnt_wdata);
  assign sh_nxt = regs_trace_cnt_wr ? wr_val : sh_p1;

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    if (!regs_trace_en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = sh_nxt;
    end else if (regs_trace_cnt_wr && state_p1 != ST_IDLE) begin
      // A rewrite restarts counting, but never pulls the core out of debug.
      cnt_nxt = wr_val;
      if (state_p1 != ST_DBG) begin
        state_nxt = ST_ARMED;
      end
    end else begin
      case (state_p1)
        ST_IDLE: begin
          state_nxt = ST_ARMED;
          cnt_nxt   = sh_nxt;
        end
        ST_ARMED: begin
          if (ev && cnt_p1 != '0) begin
            cnt_nxt = cnt_p1 - CNT_ONE;
            if (cnt_p1 == CNT_ONE) begin
              state_nxt = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          // With debug TEE-disabled the IU can never take the trace; the next
          // qualifying retirement drops it and starts a fresh count.
          if (iu_had_dbg_disable_for_tee && ev) begin
            state_nxt = ST_ARMED;
            cnt_nxt   = sh_p1;
          end else if (iu_had_trace_occur_vld) begin
            state_nxt = ST_DBG;
          end
        end
        ST_DBG: begin
          if (had_yy_xx_exit_dbg) begin
            state_nxt = ST_ARMED;
            cnt_nxt   = sh_p1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = sh_p1;
        end
      endcase
    end
  end

  assign pend_nxt = (state_nxt == ST_PEND);

  // Stage p1: state, counter, shadow and the registered request outputs.
  always_ff @(posedge cpuclk) begin
    if (hadrst) begin
      state_p1   <= ST_IDLE;
      cnt_p1     <= CNT_ONE;
      sh_p1      <= CNT_ONE;
      req_p1     <= 1'b0;
      req_dis_p1 <= 1'b0;
      pend_p1    <= 1'b0;
    end else begin
      state_p1   <= state_nxt;
      cnt_p1     <= cnt_nxt;
      sh_p1      <= sh_nxt;
      req_p1     <= pend_nxt && !iu_had_dbg_disable_for_tee;
      req_dis_p1 <= pend_nxt && iu_had_dbg_disable_for_tee;
      pend_p1    <= pend_nxt;
    end
  end

  assign trace_ctrl_req                 = req_p1;
  assign trace_ctrl_req_for_dbg_disable = req_dis_p1;
  assign trace_regs_cnt                 = cnt_p1;
  assign trace_regs_pend                = pend_p1;

endmodule
